counter_updown_mod: RTL and testbench
=====================================

# counter_updown_mod

Parametrised synchronous up/down modulo counter with parallel load, synchronous clear, enable gating and a direction-aware ripple-carry output for cascading. It succeeds the team's 4-bit ripple counter. All flops share a single clock, so there are no derived clocks and no ripple skew. Width, modulus and wrap/saturate mode are build-time choices. It is the standard counting element for timers, dividers and address generators in the design.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..32.
- MODULO, 2**WIDTH, count range is 0..MODULO-1; legal range 2..2**WIDTH.
- SATURATE, 0, selects end-of-range behaviour: 0 = wrap at the end of range; 1 = hold at the end of range.

- clk  in  1  rising-edge clock; the only clock in the block.
- rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load of din.
- din  in  WIDTH  load value.
- en  in  1  count enable; also the cascade input from a lower stage's rco.
- up  in  1  direction: 1 = increment, 0 = decrement.
- count  out  WIDTH  registered counter value.
- tc  out  1  terminal count, not gated by en.
  - up=1: asserted when count==MODULO-1.
  - up=0: asserted when count==0.
- rco  out  1  ripple carry, equal to tc & en; feeds the en of the next stage.
- ovf  out  1  one-cycle registered pulse: a wrap (SATURATE=0) or a blocked step at the limit (SATURATE=1) occurred.

## Operation
- Reset (rst_n=0): count=0 and ovf=0 immediately, without waiting for clk.
  - tc follows combinationally: tc=1 if up=0, tc=0 if up=1.
  - rco = tc & en.
- Per-edge priority: clr > load > en > hold.
- clr=1: count<=0, ovf<=0; load and en are ignored.
- load=1 (clr=0): count<=din, ovf<=0.
  - If din>=MODULO, count<=MODULO-1 (clamped).
- en=1 (clr=0, load=0), up=1:
  - count<MODULO-1: count<=count+1.
  - count==MODULO-1: SATURATE=0 gives count<=0; SATURATE=1 holds the value. In both cases ovf<=1.
- en=1 (clr=0, load=0), up=0:
  - count>0: count<=count-1.
  - count==0: SATURATE=0 gives count<=MODULO-1; SATURATE=1 holds the value. In both cases ovf<=1.
- en=0: count holds, ovf<=0.
- ovf is 0 on every edge that is not an end-of-range step.
- Arithmetic is modulo MODULO, never modulo 2**WIDTH.
  - For non-power-of-two MODULO, values MODULO..2**WIDTH-1 are unreachable except by a fault.
  - If such a value appears (e.g. an SEU), the next enabled step goes to 0 when up=1 and to MODULO-1 when up=0.
- A direction change takes effect on the same edge as the step that uses it. No turnaround cycle.

## Timing
- count and ovf are registered: 1-cycle latency from the controlling inputs at the edge.
- tc and rco are combinational from count, up and en; no added latency.
  - Cascaded stages all update on the same edge.
  - The carry path through N stages is N AND gates long.
- Reset assertion is asynchronous. Reset deassertion must meet recovery/removal to clk; the first enabled step happens on the first edge after deassertion.
- rst_n mid-count forces count=0 within the reset-to-output delay. No partial update occurs on the edge coincident with reset.
- clr or load asserted together with en: no step is taken that cycle, and ovf=0.

## Test plan
- Reset, WIDTH=4, MODULO=16, up=1, en=1, 20 clocks:
  - rst_n=0 gives count=0, tc=0.
  - count runs 0..15 and then 0.
  - tc=1 and rco=1 only at 15; ovf pulses on the 15->0 edge.
- Decade mode, MODULO=10, up=0 from reset:
  - First step 0->9 with ovf=1, then 9,8..0.
  - tc=rco=1 at 0 only.
  - load din=12 gives count=9 (clamp).
- Saturate, SATURATE=1, MODULO=16:
  - load din=14, up=1, en=1, 3 clocks: count 15,15,15; ovf=1 on the 2nd and 3rd edges.
  - Switch to up=0: count steps to 14.
- Priority:
  - clr=1, load=1, en=1 at count=7: next count=0.
  - load=1, en=1, din=3: next count=3, no increment, ovf=0.
  - en=0: count holds, rco=0 even though tc=1 at 15.
- Cascade: two WIDTH=4 instances, the lower stage's rco driving the upper stage's en.
  - Count 0x00 up to 0xFF and wrap to 0x00; the upper stage increments exactly when the lower goes 15->0.
  - Repeat with up=0 from 0x00: 0xFF, then 0xFE.
- Async reset mid-count at count=0xA with rst_n pulsed between edges: count=0 before the next edge; counting resumes 1,2 after release.

Source files
------------

// File: rtl/counter_updown_mod.sv
// rtl/counter_updown_mod.sv - parametrised up/down modulo counter with load, clear and cascade carry
module counter_updown_mod #(
    parameter int unsigned          WIDTH    = 4,
    parameter longint unsigned      MODULO   = 64'(1) << WIDTH,
    parameter bit                   SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             rco,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 64'(1));

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (din > MAX_VAL) ? MAX_VAL : din;
        end else if (en) begin
            if (up) begin
                if (count_q < MAX_VAL) begin
                    count_d = count_q + WIDTH'(1);
                end else if (count_q == MAX_VAL) begin
                    ovf_d   = 1'b1;
                    count_d = SATURATE ? MAX_VAL : '0;
                end else begin
                    // Out-of-range value (only reachable by a fault): recover to 0.
                    count_d = '0;
                end
            end else begin
                if (count_q > MAX_VAL) begin
                    count_d = MAX_VAL;
                end else if (count_q == '0) begin
                    ovf_d   = 1'b1;
                    count_d = SATURATE ? '0 : MAX_VAL;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Terminal count is direction-aware and ungated so cascades can look ahead.
    assign tc    = up ? (count_q == MAX_VAL) : (count_q == '0);
    assign rco   = tc & en;
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb/tb_counter_updown_mod.sv - directed self-checking bench for counter_updown_mod
module tb_counter_updown_mod;

    logic clk;
    logic rst_n;

    logic       clr_a, load_a, en_a, up_a;
    logic [3:0] din_a, count_a;
    logic       tc_a, rco_a, ovf_a;

    logic       clr_b, load_b, en_b, up_b;
    logic [3:0] din_b, count_b;
    logic       tc_b, rco_b, ovf_b;

    logic       clr_c, load_c, en_c, up_c;
    logic [3:0] din_c, count_c;
    logic       tc_c, rco_c, ovf_c;

    logic       clr_x, en_x, up_x;
    logic [3:0] din_x, count_lo, count_hi;
    logic       tc_lo, rco_lo, ovf_lo, tc_hi, rco_hi, ovf_hi;

    int checks = 0;
    int errors = 0;

    counter_updown_mod #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr_a), .load(load_a), .din(din_a), .en(en_a), .up(up_a),
        .count(count_a), .tc(tc_a), .rco(rco_a), .ovf(ovf_a));

    counter_updown_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr_b), .load(load_b), .din(din_b), .en(en_b), .up(up_b),
        .count(count_b), .tc(tc_b), .rco(rco_b), .ovf(ovf_b));

    counter_updown_mod #(.WIDTH(4), .MODULO(16), .SATURATE(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr_c), .load(load_c), .din(din_c), .en(en_c), .up(up_c),
        .count(count_c), .tc(tc_c), .rco(rco_c), .ovf(ovf_c));

    counter_updown_mod #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0)) u_lo (
        .clk(clk), .rst_n(rst_n), .clr(clr_x), .load(1'b0), .din(din_x), .en(en_x), .up(up_x),
        .count(count_lo), .tc(tc_lo), .rco(rco_lo), .ovf(ovf_lo));

    counter_updown_mod #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0)) u_hi (
        .clk(clk), .rst_n(rst_n), .clr(clr_x), .load(1'b0), .din(din_x), .en(rco_lo), .up(up_x),
        .count(count_hi), .tc(tc_hi), .rco(rco_hi), .ovf(ovf_hi));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr_a = 0; load_a = 0; en_a = 1; up_a = 1; din_a = 0;
        clr_b = 0; load_b = 0; en_b = 0; up_b = 0; din_b = 0;
        clr_c = 0; load_c = 0; en_c = 0; up_c = 1; din_c = 0;
        clr_x = 0; en_x = 0; up_x = 1; din_x = 0;
        #1;
        chk("rst_count_a", 32'(count_a), 32'd0);
        chk("rst_tc_a_up", 32'(tc_a), 32'd0);
        chk("rst_ovf_a", 32'(ovf_a), 32'd0);
        chk("rst_tc_b_down", 32'(tc_b), 32'd1);
        chk("rst_rco_b_en0", 32'(rco_b), 32'd0);
        step();
        chk("rst_hold_a", 32'(count_a), 32'd0);
        rst_n = 1'b1;

        // Mod-16 wrap run
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("run16_count", 32'(count_a), 32'(i % 16));
            chk("run16_tc", 32'(tc_a), 32'((i % 16) == 15));
            chk("run16_rco", 32'(rco_a), 32'((i % 16) == 15));
            chk("run16_ovf", 32'(ovf_a), 32'(i == 16));
        end
        en_a = 0;

        // Decade down-count
        en_b = 1;
        step();
        chk("dec_first_count", 32'(count_b), 32'd9);
        chk("dec_first_ovf", 32'(ovf_b), 32'd1);
        for (int i = 2; i <= 10; i++) begin
            step();
            chk("dec_count", 32'(count_b), 32'(10 - i));
            chk("dec_ovf", 32'(ovf_b), 32'd0);
            chk("dec_tc", 32'(tc_b), 32'(i == 10));
            chk("dec_rco", 32'(rco_b), 32'(i == 10));
        end
        en_b = 0; load_b = 1; din_b = 4'd12;
        step();
        chk("dec_load_clamp", 32'(count_b), 32'd9);
        load_b = 0;

        // Saturating counter
        load_c = 1; din_c = 4'd14;
        step();
        chk("sat_load", 32'(count_c), 32'd14);
        load_c = 0; en_c = 1; up_c = 1;
        step();
        chk("sat_c1", 32'(count_c), 32'd15);
        chk("sat_o1", 32'(ovf_c), 32'd0);
        step();
        chk("sat_c2", 32'(count_c), 32'd15);
        chk("sat_o2", 32'(ovf_c), 32'd1);
        step();
        chk("sat_c3", 32'(count_c), 32'd15);
        chk("sat_o3", 32'(ovf_c), 32'd1);
        up_c = 0;
        step();
        chk("sat_down", 32'(count_c), 32'd14);
        chk("sat_down_ovf", 32'(ovf_c), 32'd0);
        en_c = 0;

        // Priority: clr > load > en
        load_a = 1; din_a = 4'd7;
        step();
        chk("pri_load7", 32'(count_a), 32'd7);
        clr_a = 1; load_a = 1; en_a = 1; din_a = 4'd5;
        step();
        chk("pri_clr", 32'(count_a), 32'd0);
        chk("pri_clr_ovf", 32'(ovf_a), 32'd0);
        clr_a = 0; din_a = 4'd3;
        step();
        chk("pri_load_over_en", 32'(count_a), 32'd3);
        chk("pri_load_ovf", 32'(ovf_a), 32'd0);
        din_a = 4'd15; en_a = 0;
        step();
        load_a = 0;
        step();
        chk("hold_count", 32'(count_a), 32'd15);
        chk("hold_tc", 32'(tc_a), 32'd1);
        chk("hold_rco", 32'(rco_a), 32'd0);
        up_a = 0;
        #1;
        chk("dir_tc_comb", 32'(tc_a), 32'd0);

        // Two-stage cascade, up then down
        en_x = 1; up_x = 1;
        for (int i = 1; i <= 256; i++) begin
            step();
            chk("casc_up", 32'({count_hi, count_lo}), 32'(i % 256));
        end
        up_x = 0;
        step();
        chk("casc_dn1", 32'({count_hi, count_lo}), 32'hFF);
        step();
        chk("casc_dn2", 32'({count_hi, count_lo}), 32'hFE);
        en_x = 0;

        // Async reset between edges
        load_a = 1; din_a = 4'hA;
        step();
        chk("ar_load", 32'(count_a), 32'hA);
        load_a = 0; en_a = 1; up_a = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count0", 32'(count_a), 32'd0);
        chk("ar_ovf0", 32'(ovf_a), 32'd0);
        #2 rst_n = 1'b1;
        step();
        chk("ar_resume1", 32'(count_a), 32'd1);
        step();
        chk("ar_resume2", 32'(count_a), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
